// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data-side SRAM responder.
// State encoding and wait counter width live here so every file agrees on them.
package data_sram_responder_pkg;

  localparam int DSRAM_WAIT_W = 4;

  typedef enum logic [0:0] {
    DSRAM_IDLE = 1'b0,
    DSRAM_BUSY = 1'b1
  } dsramState_e;

  // An access with no byte lanes enabled is a read.
  function automatic logic isRead(input logic [3:0] wen);
    return (wen == 4'b0000);
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// The data_sram_* bus between EX/MEM (master) and the memory responder (slave).
interface data_sram_responder_if;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_mem;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata,
    input  stallreq_mem
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata,
    output stallreq_mem
  );

endinterface

// File: rtl/data_sram_responder_lane.sv
// One byte lane of the data SRAM: 8-bit x 2^ADDR_W single-port array with registered read.
module dsram_lane #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [2**ADDR_W];
  logic [7:0] rdata_q;

  // Array contents are deliberately outside reset so the storage maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Memory end of the data_sram_* bus: byte-lane writes, registered reads and optional
// wait states that raise stallreq_mem so the pipeline can be run against slow memory.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  data_sram_responder_if.slave   bus
);

  localparam logic [DSRAM_WAIT_W-1:0] CNT_LOAD =
    DSRAM_WAIT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  dsramState_e             state_q, state_d;
  logic [DSRAM_WAIT_W-1:0] cnt_q, cnt_d;
  logic                    accessFire;
  logic                    stallReq;
  logic [ADDR_W-1:0]       wordIndex;
  logic                    unusedAddrBits;

  // Byte offset and bits above the array depth are dropped, so addresses alias modulo depth.
  assign wordIndex      = bus.data_sram_addr[ADDR_W+1:2];
  assign unusedAddrBits = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accessFire = 1'b0;
    stallReq   = 1'b0;
    unique case (state_q)
      DSRAM_IDLE: begin
        if (bus.data_sram_en) begin
          if (WAIT_CYCLES == 0) begin
            accessFire = 1'b1;
          end else begin
            stallReq = 1'b1;
            state_d  = DSRAM_BUSY;
            cnt_d    = CNT_LOAD;
          end
        end
      end
      DSRAM_BUSY: begin
        if (!bus.data_sram_en) begin
          state_d = DSRAM_IDLE;
        end else if (cnt_q != '0) begin
          stallReq = 1'b1;
          cnt_d    = cnt_q - DSRAM_WAIT_W'(1);
        end else begin
          accessFire = 1'b1;
          state_d    = DSRAM_IDLE;
        end
      end
      default: state_d = DSRAM_IDLE;
    endcase
    // Reset wins over everything, including a completing write.
    if (rst) begin
      accessFire = 1'b0;
      stallReq   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DSRAM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stallreq_mem = stallReq;

  for (genvar lane = 0; lane < 4; lane++) begin : gLane
    dsram_lane #(
      .ADDR_W (ADDR_W)
    ) uLane (
      .clk     (clk),
      .rst     (rst),
      .we_i    (accessFire && bus.data_sram_wen[lane]),
      .re_i    (accessFire && isRead(bus.data_sram_wen)),
      .addr_i  (wordIndex),
      .wdata_i (bus.data_sram_wdata[8*lane +: 8]),
      .rdata_o (bus.data_sram_rdata[8*lane +: 8])
    );
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: three responders (WAIT_CYCLES 0, 3, 2) driven one at a time
// from shared stimulus and compared against a word-array reference model.
module tb_data_sram_responder;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 2**ADDR_W;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  int          sel;
  logic [31:0] curRdata;
  logic        curStall;

  int checks;
  int errors;
  int waitOf [3];

  logic [31:0] modelMem [3][DEPTH];
  logic [31:0] modelRd  [3];

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
  } vector_t;

  vector_t vecs [7];

  data_sram_responder_if if0 ();
  data_sram_responder_if if1 ();
  data_sram_responder_if if2 ();

  // Only the selected responder sees en; the others idle and keep their state.
  assign if0.data_sram_en    = en && (sel == 0);
  assign if1.data_sram_en    = en && (sel == 1);
  assign if2.data_sram_en    = en && (sel == 2);
  assign if0.data_sram_wen   = wen;
  assign if1.data_sram_wen   = wen;
  assign if2.data_sram_wen   = wen;
  assign if0.data_sram_addr  = addr;
  assign if1.data_sram_addr  = addr;
  assign if2.data_sram_addr  = addr;
  assign if0.data_sram_wdata = wdata;
  assign if1.data_sram_wdata = wdata;
  assign if2.data_sram_wdata = wdata;

  data_sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  data_sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  data_sram_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  always_comb begin
    curRdata = if0.data_sram_rdata;
    curStall = if0.stallreq_mem;
    if (sel == 1) begin
      curRdata = if1.data_sram_rdata;
      curStall = if1.stallreq_mem;
    end else if (sel == 2) begin
      curRdata = if2.data_sram_rdata;
      curStall = if2.stallreq_mem;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst=%0d actual=%h required=%h", name, sel, act, exp);
    end
  endtask

  // Holds one request for WAIT_CYCLES+1 cycles, then updates the word-level model.
  task automatic applyStimulus(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    int idx;
    en    = 1'b1;
    wen   = w;
    addr  = a;
    wdata = d;
    for (int c = 0; c <= waitOf[sel]; c++) begin
      #1;
      checkOutput("stall", {31'b0, curStall}, (c < waitOf[sel]) ? 32'd1 : 32'd0);
      checkOutput("rdataHold", curRdata, modelRd[sel]);
      @(posedge clk);
      @(negedge clk);
    end
    idx = int'((a >> 2) % DEPTH);
    if (w == 4'b0000) begin
      modelRd[sel] = modelMem[sel][idx];
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (w[l]) modelMem[sel][idx][8*l +: 8] = d[8*l +: 8];
      end
    end
    checkOutput("rdata", curRdata, modelRd[sel]);
  endtask

  task automatic idleCycle();
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  rw;
    logic [31:0] ra;
    checks    = 0;
    errors    = 0;
    waitOf[0] = 0;
    waitOf[1] = 3;
    waitOf[2] = 2;
    rst   = 1'b1;
    en    = 1'b0;
    wen   = 4'b0;
    addr  = '0;
    wdata = '0;
    sel   = 0;
    for (int i = 0; i < 3; i++) modelRd[i] = '0;

    vecs[0] = '{4'hF, 32'h100,  32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{4'h0, 32'h100,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{4'hF, 32'h40,   32'h11223344, 32'hDEADBEEF};
    vecs[3] = '{4'h4, 32'h40,   32'h00AA0000, 32'hDEADBEEF};
    vecs[4] = '{4'h0, 32'h43,   32'h0,        32'h11AA3344};
    vecs[5] = '{4'hF, 32'h4010, 32'h0000CAFE, 32'h11AA3344};
    vecs[6] = '{4'h0, 32'h0010, 32'h0,        32'h0000CAFE};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      checkOutput("resetRdata", curRdata, 32'h0);
      checkOutput("resetStall", {31'b0, curStall}, 32'h0);
    end
    @(negedge clk);

    // Zero-wait instance: full write, byte-lane merge and aliasing.
    sel = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      checkOutput("vector", curRdata, vecs[i].expRdata);
    end
    idleCycle();

    // Three wait states: stall for cycles 1-3, data after the fourth.
    sel = 1;
    applyStimulus(4'hF, 32'h20, 32'hCAFEBABE);
    applyStimulus(4'h0, 32'h20, 32'h0);
    checkOutput("wait3Read", curRdata, 32'hCAFEBABE);
    applyStimulus(4'h0, 32'h20, 32'h0);
    idleCycle();

    // Abandoned write: en drops in the second cycle.
    sel = 2;
    applyStimulus(4'hF, 32'h80, 32'h12345678);
    en = 1'b1; wen = 4'hF; addr = 32'h80; wdata = 32'hFFFFFFFF;
    #1 checkOutput("abandonStall1", {31'b0, curStall}, 32'h1);
    @(posedge clk); @(negedge clk);
    en = 1'b0;
    #1 checkOutput("abandonStall2", {31'b0, curStall}, 32'h0);
    @(posedge clk); @(negedge clk);
    applyStimulus(4'h0, 32'h80, 32'h0);
    checkOutput("abandonRead", curRdata, 32'h12345678);

    // Reset in BUSY aborts the write and clears rdata.
    applyStimulus(4'hF, 32'h84, 32'hA5A5A5A5);
    en = 1'b1; wen = 4'hF; addr = 32'h84; wdata = 32'h0;
    #1 checkOutput("rstBusyStall", {31'b0, curStall}, 32'h1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("rstForcedStall", {31'b0, curStall}, 32'h0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    for (int i = 0; i < 3; i++) modelRd[i] = '0;
    #1 checkOutput("rstRdata", curRdata, 32'h0);
    @(negedge clk);
    applyStimulus(4'h0, 32'h84, 32'h0);
    checkOutput("rstRead", curRdata, 32'hA5A5A5A5);
    idleCycle();

    // Back-to-back write/read over eight consecutive words.
    for (int s = 0; s < 3; s += 2) begin
      sel = s;
      for (int i = 0; i < 8; i++) begin
        applyStimulus(4'hF, 32'h200 + 32'(4*i), $urandom);
        applyStimulus(4'h0, 32'h200 + 32'(4*i), 32'h0);
      end
      idleCycle();
    end

    // Random traffic over a small pool of words, with aliased and unaligned addresses.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int k = 0; k < 8; k++) applyStimulus(4'hF, 32'h300 + 32'(4*k), $urandom);
      for (int n = 0; n < 40; n++) begin
        rw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        ra = 32'h300 + 32'(4*$urandom_range(0, 7)) + 32'($urandom_range(0, 3))
             + (32'($urandom_range(0, 3)) << 14);
        applyStimulus(rw, ra, $urandom);
        if ($urandom_range(0, 3) == 0) idleCycle();
      end
      idleCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
